// File: rtl/spi_slave_core.sv
// Oversampled single-clock SPI slave: all four CPOL/CPHA modes, MSB/LSB order, one-entry TX buffer, RX holding register.
// Optional: define SPI_SLAVE_OVERRUN_EN to drop words that complete while rx_valid is still pending, and pulse err.
module spi_slave_core #(
   parameter int DW          = 8,
   parameter int SS_IDX      = 0,
   parameter int SYNC_STAGES = 2,
   parameter int SPI_SS_NB   = 8
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 sclk,
   input  logic                 mosi,
   input  logic [SPI_SS_NB-1:0] ss_pad_o,
   input  logic                 cpol,
   input  logic                 cpha,
   input  logic                 lsb,
   input  logic [DW-1:0]        tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DW-1:0]        rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 miso,
   output logic                 miso_oe,
   output logic                 busy,
   output logic                 err
);

   localparam int CW = $clog2(DW);

   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t r_state, w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
   logic                   r_sclk_d, r_ss_d;
   logic                   r_cpol, r_cpha, r_lsb, r_ld_pend;
   logic [CW-1:0]          r_cnt;
   logic [DW-1:0]          r_tx_buf, r_tx_sh, r_rx_sh, r_rx_data, r_infl;
   logic                   r_tx_full, r_infl_vld, r_rx_valid, r_miso, r_err;

   logic          w_sclk_s, w_mosi_s, w_ss_s, w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
   logic          w_lead, w_trail, w_start, w_stop, w_sample, w_shift, w_done, w_first;
   logic          w_pop, w_push, w_underrun, w_overrun, w_restore, w_unused_ss;
   logic [DW-1:0] w_tx_word, w_rx_next;

   function automatic logic first_bit(input logic [DW-1:0] x, input logic l);
      return l ? x[0] : x[DW-1];
   endfunction

   function automatic logic [DW-1:0] shift_word(input logic [DW-1:0] x, input logic l);
      return l ? (x >> 1) : (x << 1);
   endfunction

   // Synchronisers are left unreset so a select held low through reset never looks like a fresh assertion.
   always_ff @(posedge wb_clk_i) begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_pad_o[SS_IDX]};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
   end

   assign w_unused_ss = ^ss_pad_o;
   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
   assign w_ss_fall   = r_ss_d & ~w_ss_s;
   assign w_ss_rise   = ~r_ss_d & w_ss_s;
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_lead      = r_cpol ? w_sclk_fall : w_sclk_rise;
   assign w_trail     = r_cpol ? w_sclk_rise : w_sclk_fall;

   assign w_start    = (r_state == IDLE) & w_ss_fall;
   assign w_stop     = (r_state == ACTIVE) & w_ss_rise;
   assign w_sample   = (r_state == ACTIVE) & ~w_ss_rise & (r_cpha ? w_trail : w_lead);
   assign w_shift    = (r_state == ACTIVE) & ~w_ss_rise & (r_cpha ? w_lead : w_trail);
   assign w_done     = w_sample & (r_cnt == CW'(DW-1));
   assign w_first    = w_sample & (r_cnt == '0);
   assign w_tx_word  = r_tx_full ? r_tx_buf : '0;
   assign w_push     = tx_valid & ~r_tx_full;
   assign w_pop      = w_first & r_tx_full;
   assign w_underrun = w_first & ~r_tx_full;
   // A word popped but not finished goes back into an empty buffer, so the next frame resends it.
   assign w_restore  = w_stop & r_infl_vld & ~r_tx_full;
   assign w_rx_next  = r_lsb ? {w_mosi_s, r_rx_sh[DW-1:1]} : {r_rx_sh[DW-2:0], w_mosi_s};
`ifdef SPI_SLAVE_OVERRUN_EN
   assign w_overrun  = w_done & r_rx_valid & ~rx_ready;
`else
   assign w_overrun  = 1'b0;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_ss_fall) w_state_nxt = ACTIVE;
         ACTIVE:  if (w_ss_rise) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_cnt      <= '0;
         r_miso     <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
         r_err      <= 1'b0;
         r_tx_full  <= 1'b0;
         r_infl_vld <= 1'b0;
         r_ld_pend  <= 1'b0;
         r_cpol     <= 1'b0;
         r_cpha     <= 1'b0;
         r_lsb      <= 1'b0;
      end else begin
         r_err <= w_underrun | w_overrun;

         if (w_push) begin
            r_tx_full <= 1'b1;
            r_tx_buf  <= tx_data;
         end else if (w_restore) begin
            r_tx_full <= 1'b1;
            r_tx_buf  <= r_infl;
         end else if (w_pop) begin
            r_tx_full <= 1'b0;
         end

         if (w_pop) begin
            r_infl_vld <= 1'b1;
            r_infl     <= r_tx_buf;
         end else if (w_done | w_stop) begin
            r_infl_vld <= 1'b0;
         end

         if (w_start) begin
            r_cpol    <= cpol;
            r_cpha    <= cpha;
            r_lsb     <= lsb;
            r_cnt     <= '0;
            r_ld_pend <= cpha;
            if (!cpha) begin
               r_miso  <= first_bit(w_tx_word, lsb);
               r_tx_sh <= shift_word(w_tx_word, lsb);
            end
         end

         if (w_stop) begin
            r_miso    <= 1'b0;
            r_ld_pend <= 1'b0;
         end

         if (w_sample) begin
            r_rx_sh <= w_rx_next;
            r_cnt   <= w_done ? '0 : r_cnt + CW'(1);
            if (w_done) begin
               if (r_cpha) r_ld_pend <= 1'b1;
               else        r_tx_sh   <= w_tx_word;
            end
         end

         if (w_shift) begin
            if (r_ld_pend) begin
               r_miso    <= first_bit(w_tx_word, r_lsb);
               r_tx_sh   <= shift_word(w_tx_word, r_lsb);
               r_ld_pend <= 1'b0;
            end else begin
               r_miso    <= first_bit(r_tx_sh, r_lsb);
               r_tx_sh   <= shift_word(r_tx_sh, r_lsb);
            end
         end

         if (w_done & ~w_overrun) begin
            r_rx_data  <= w_rx_next;
            r_rx_valid <= 1'b1;
         end else if (r_rx_valid & rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign tx_ready = ~r_tx_full;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign miso     = r_miso;
   assign miso_oe  = (r_state == ACTIVE);
   assign busy     = (r_state == ACTIVE);
   assign err      = r_err;

endmodule
